// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared constants and default maximal-length tap masks for lfsr_param.
package lfsr_pkg;
  localparam int MODE_FIBONACCI = 0;
  localparam int MODE_GALOIS = 1;
  localparam int WIDTH_MIN = 3;
  localparam int WIDTH_MAX = 32;
  function automatic logic [31:0] default_taps(input int w);
    case (w)
      3: return 32'h6;
      4: return 32'hC;
      5: return 32'h14;
      6: return 32'h30;
      7: return 32'h60;
      8: return 32'hB8;
      9: return 32'h110;
      10: return 32'h240;
      11: return 32'h500;
      12: return 32'h829;
      13: return 32'h100D;
      14: return 32'h2015;
      15: return 32'h6000;
      16: return 32'hD008;
      17: return 32'h12000;
      18: return 32'h20400;
      19: return 32'h40023;
      20: return 32'h90000;
      21: return 32'h140000;
      22: return 32'h300000;
      23: return 32'h420000;
      24: return 32'hE10000;
      25: return 32'h1200000;
      26: return 32'h2000023;
      27: return 32'h4000013;
      28: return 32'h9000000;
      29: return 32'h14000000;
      30: return 32'h20000029;
      31: return 32'h48000000;
      32: return 32'h80200003;
      default: return 32'h0;
    endcase
  endfunction
endpackage

// File: rtl/lfsr_param_if.sv
// lfsr_param_if: control, seed/taps and status bundle for lfsr_param.
interface lfsr_param_if #(parameter int WIDTH = 8);
  logic enable;
  logic load;
  logic [WIDTH-1:0] reset_value;
  logic [WIDTH-1:0] taps;
  logic [WIDTH-1:0] computed_value;
  logic lockup;
  logic [WIDTH-1:0] period_length;
  logic period_valid;
  modport master(output enable, load, reset_value, taps,
                 input computed_value, lockup, period_length, period_valid);
  modport slave(input enable, load, reset_value, taps,
                output computed_value, lockup, period_length, period_valid);
endinterface

// File: rtl/lfsr_next.sv
// lfsr_next: combinational one-step successor for a Fibonacci or Galois LFSR.
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MODE = MODE_FIBONACCI
) (
  input  logic [WIDTH-1:0] state,
  input  logic [WIDTH-1:0] taps,
  output logic [WIDTH-1:0] next
);
  logic m;
  // Galois ignores taps[WIDTH-1]: the x^WIDTH term is implied by the shift-out bit.
  always_comb begin
    m = state[WIDTH-1];
    next = (MODE == MODE_GALOIS) ?
           ({state[WIDTH-2:0], m} ^ ({WIDTH{m}} & {taps[WIDTH-2:0], 1'b0})) :
           {state[WIDTH-2:0], ^(state & taps)};
  end
endmodule

// File: rtl/lfsr_param.sv
// lfsr_param: parametrised LFSR with seed load, lock-up recovery and an optional
// period counter enabled by defining LFSR_PERIOD_CNT_EN.
module lfsr_param
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MODE = MODE_FIBONACCI,
  parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
  input logic clock,
  input logic reset,
  lfsr_param_if.slave bus
);
  logic [WIDTH-1:0] state_q, state_d, step;
  logic lock, recover;
  lfsr_next #(.WIDTH(WIDTH), .MODE(MODE)) u_next (
    .state(state_q),
    .taps(bus.taps),
    .next(step)
  );
  // A zero state can never leave itself, so an enabled step reseeds instead.
  always_comb begin
    lock = (state_q == '0);
    recover = bus.enable && !bus.load && lock;
    state_d = bus.load ? bus.reset_value :
              recover ? RESET_VALUE :
              bus.enable ? step : state_q;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) state_q <= RESET_VALUE;
    else state_q <= state_d;
  assign bus.computed_value = state_q;
  assign bus.lockup = lock;
`ifdef LFSR_PERIOD_CNT_EN
  logic [WIDTH-1:0] start_q, start_d, count_q, count_d, plen_q, plen_d;
  logic pvalid_q, pvalid_d, wrap;
  // Period ends when the next state returns to the state captured at (re)start.
  always_comb begin
    wrap = bus.enable && !bus.load && !lock && (step == start_q);
    start_d = bus.load ? bus.reset_value : recover ? RESET_VALUE : start_q;
    count_d = (bus.load || recover || wrap) ? '0 :
              bus.enable ? count_q + WIDTH'(1) : count_q;
    plen_d = wrap ? count_q + WIDTH'(1) : plen_q;
    pvalid_d = wrap;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      start_q <= RESET_VALUE;
      count_q <= '0;
      plen_q <= '0;
      pvalid_q <= 1'b0;
    end else begin
      start_q <= start_d;
      count_q <= count_d;
      plen_q <= plen_d;
      pvalid_q <= pvalid_d;
    end
  assign bus.period_length = plen_q;
  assign bus.period_valid = pvalid_q;
`else
  assign bus.period_length = '0;
  assign bus.period_valid = 1'b0;
`endif
endmodule

// File: tb/tb_lfsr_param.sv
// tb_lfsr_param: directed checks of an 8-bit Fibonacci and a 4-bit Galois lfsr_param.
module tb_lfsr_param;
`ifdef LFSR_PERIOD_CNT_EN
  localparam bit PC = 1'b1;
`else
  localparam bit PC = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clock = ~clock;
  lfsr_param_if #(.WIDTH(8)) fi ();
  lfsr_param_if #(.WIDTH(4)) gi ();
  lfsr_param #(.WIDTH(8), .MODE(0)) u_fib (.clock(clock), .reset(reset), .bus(fi));
  lfsr_param #(.WIDTH(4), .MODE(1)) u_gal (.clock(clock), .reset(reset), .bus(gi));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
  initial begin
    logic [7:0] fexp [1:5];
    logic [3:0] gexp [1:4];
    int pulses;
    int at;
    fexp[1] = 8'hFE; fexp[2] = 8'hFC; fexp[3] = 8'hF8; fexp[4] = 8'hF0; fexp[5] = 8'hE1;
    gexp[1] = 4'h3; gexp[2] = 4'h6; gexp[3] = 4'hC; gexp[4] = 4'hB;
    fi.enable = 0; fi.load = 0; fi.reset_value = 8'hFF; fi.taps = 8'hB8;
    gi.enable = 0; gi.load = 0; gi.reset_value = 4'h8; gi.taps = 4'h1;
    #12;
    check("rst_fib_value", fi.computed_value, 8'hFF);
    check("rst_fib_lockup", fi.lockup, 0);
    check("rst_fib_plen", fi.period_length, 0);
    check("rst_fib_pvalid", fi.period_valid, 0);
    check("rst_gal_value", gi.computed_value, 4'hF);
    reset = 1;
    fi.load = 1; fi.enable = 1;
    tick();
    check("fib_load_over_enable", fi.computed_value, 8'hFF);
    fi.load = 0;
    pulses = 0; at = 0;
    for (int i = 1; i <= 255; i++) begin
      tick();
      if (i <= 5) check($sformatf("fib_step%0d", i), fi.computed_value, fexp[i]);
      if (fi.period_valid) begin pulses++; at = i; end
    end
    check("fib_period_return", fi.computed_value, 8'hFF);
    check("fib_pulse_count", pulses, PC ? 1 : 0);
    check("fib_pulse_step", at, PC ? 255 : 0);
    check("fib_period_length", fi.period_length, PC ? 255 : 0);
    fi.enable = 0;
    repeat (10) tick();
    check("fib_hold_value", fi.computed_value, 8'hFF);
    check("fib_hold_pvalid", fi.period_valid, 0);
    check("fib_hold_plen", fi.period_length, PC ? 255 : 0);
    fi.load = 1; fi.enable = 1; fi.reset_value = 8'h5A;
    tick();
    check("fib_load_5a", fi.computed_value, 8'h5A);
    fi.load = 0;
    tick();
    check("fib_step_5a", fi.computed_value, 8'hB4);
    fi.reset_value = 8'h00; fi.load = 1;
    tick();
    check("zero_seed_value", fi.computed_value, 8'h00);
    check("zero_seed_lockup", fi.lockup, 1);
    fi.load = 0; fi.enable = 0;
    tick();
    check("lockup_hold", fi.lockup, 1);
    fi.enable = 1;
    tick();
    check("recover_value", fi.computed_value, 8'hFF);
    check("recover_lockup", fi.lockup, 0);
    tick();
    check("post_recover_step", fi.computed_value, 8'hFE);
    #2;
    reset = 0;
    #1;
    check("async_rst_value", fi.computed_value, 8'hFF);
    check("async_rst_lockup", fi.lockup, 0);
    check("async_rst_plen", fi.period_length, 0);
    check("async_rst_pvalid", fi.period_valid, 0);
    check("async_rst_gal", gi.computed_value, 4'hF);
    #3;
    reset = 1;
    fi.enable = 0;
    gi.load = 1; gi.enable = 1;
    tick();
    check("gal_load", gi.computed_value, 4'h8);
    gi.load = 0;
    pulses = 0; at = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i <= 4) check($sformatf("gal_step%0d", i), gi.computed_value, gexp[i]);
      if (gi.period_valid) begin pulses++; at = i; end
    end
    check("gal_period_return", gi.computed_value, 4'h8);
    check("gal_pulse_count", pulses, PC ? 1 : 0);
    check("gal_pulse_step", at, PC ? 15 : 0);
    check("gal_period_length", gi.period_length, PC ? 15 : 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
